// File: rtl/fsk_pkg.sv
// Shared types and constants for the framed FSK symbol source.
package fsk_pkg;

  localparam int SYM_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    PAYLOAD,
    DRAIN
  } fsk_state_t;

  localparam logic [SYM_W-1:0] PRE_A = 5'h00;
  localparam logic [SYM_W-1:0] PRE_B = 5'h1F;

  // Sync word goes out MSB-first, one 5-bit slice per symbol.
  function automatic logic [SYM_W-1:0] sync_sym(input logic [14:0] word,
                                                input logic [1:0]  idx);
    case (idx)
      2'd0:    return word[14:10];
      2'd1:    return word[9:5];
      default: return word[4:0];
    endcase
  endfunction

endpackage

// File: rtl/fsk_frame_src_if.sv
// Payload byte stream into the frame source.
// Handshake: a byte moves on a clock edge where din_valid && din_ready are both
// high; the master holds din/din_last stable while din_valid waits for ready.
interface fsk_frame_src_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_last;
  logic       din_ready;

  modport master (output din, output din_valid, output din_last, input din_ready);
  modport slave  (input din, input din_valid, input din_last, output din_ready);
endinterface

// File: rtl/fsk_byte_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
module fsk_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fsk_frame_src.sv
// Framed symbol source: preamble, sync word, then payload packed 5 bits per
// symbol, one symbol per enable strobe, fed from a small byte FIFO.
module fsk_frame_src
  import fsk_pkg::*;
#(
  parameter int               PREAMBLE_LEN = 8,
  parameter logic [14:0]      SYNC_WORD    = 15'h4D2B,
  parameter int               FIFO_DEPTH   = 4,
  parameter logic [SYM_W-1:0] IDLE_SYM     = 5'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  fsk_frame_src_if.slave    byte_in,
  output logic [SYM_W-1:0]  address,
  output logic              sym_valid,
  output logic              busy,
  output logic              underrun,
  output fsk_state_t        state_dbg
);

  localparam int IDX_W = ($clog2(PREAMBLE_LEN) < 2) ? 2 : $clog2(PREAMBLE_LEN);
  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_LEN - 1);
  localparam logic [IDX_W-1:0] SYNC_LAST = IDX_W'(2);

  fsk_state_t       state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [11:0]      bbuf, bbuf_n;
  logic [3:0]       cnt, cnt_n;
  logic             last_popped, last_popped_n;
  logic [SYM_W-1:0] address_n;
  logic             sym_valid_n;
  logic             underrun_n;

  logic             ready_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             fifo_push;
  logic [8:0]       fifo_rdata;
  logic             in_frame;

  // Ready stays low through reset and rises on the first edge after release.
  assign byte_in.din_ready = ready_q && !fifo_full;
  assign fifo_push         = byte_in.din_valid && byte_in.din_ready;

  fsk_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({byte_in.din_last, byte_in.din}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_frame  = (state == PREAMBLE) || (state == SYNC) || (state == PAYLOAD);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      state       <= IDLE;
      idx         <= '0;
      bbuf        <= '0;
      cnt         <= '0;
      last_popped <= 1'b0;
      address     <= IDLE_SYM;
      sym_valid   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      ready_q     <= 1'b1;
      state       <= state_n;
      idx         <= idx_n;
      bbuf        <= bbuf_n;
      cnt         <= cnt_n;
      last_popped <= last_popped_n;
      address     <= address_n;
      sym_valid   <= sym_valid_n;
      underrun    <= underrun_n;
    end
  end

  always_comb begin
    state_n       = state;
    idx_n         = idx;
    bbuf_n        = bbuf;
    cnt_n         = cnt;
    last_popped_n = last_popped;
    address_n     = address;
    sym_valid_n   = sym_valid;
    underrun_n    = 1'b0;
    fifo_pop      = 1'b0;

    if (!enable) begin
      // Refill between strobes; new bits land just below the valid ones.
      if (in_frame && (cnt <= 4'd4) && !fifo_empty && !last_popped) begin
        fifo_pop      = 1'b1;
        bbuf_n        = bbuf | ({fifo_rdata[7:0], 4'b0000} >> cnt);
        cnt_n         = cnt + 4'd8;
        last_popped_n = fifo_rdata[8];
      end else if ((state == DRAIN) && !fifo_empty && !last_popped) begin
        fifo_pop      = 1'b1;
        last_popped_n = fifo_rdata[8];
      end
    end else begin
      case (state)
        IDLE: begin
          address_n   = IDLE_SYM;
          sym_valid_n = 1'b0;
          if (!fifo_empty) begin
            address_n     = PRE_A;
            sym_valid_n   = 1'b1;
            idx_n         = IDX_W'(1);
            bbuf_n        = '0;
            cnt_n         = '0;
            last_popped_n = 1'b0;
            state_n       = PREAMBLE;
          end
        end

        PREAMBLE: begin
          address_n   = idx[0] ? PRE_B : PRE_A;
          sym_valid_n = 1'b1;
          if (idx == PRE_LAST) begin
            idx_n   = '0;
            state_n = SYNC;
          end else begin
            idx_n = idx + 1'b1;
          end
        end

        SYNC: begin
          address_n   = sync_sym(SYNC_WORD, idx[1:0]);
          sym_valid_n = 1'b1;
          if (idx == SYNC_LAST) begin
            idx_n   = '0;
            state_n = PAYLOAD;
          end else begin
            idx_n = idx + 1'b1;
          end
        end

        PAYLOAD: begin
          if (last_popped && (cnt <= 4'd5)) begin
            // Final partial symbol; the buffer is zero below the valid bits.
            address_n     = (cnt == 4'd0) ? IDLE_SYM : bbuf[11:7];
            sym_valid_n   = (cnt != 4'd0);
            bbuf_n        = '0;
            cnt_n         = '0;
            last_popped_n = 1'b0;
            state_n       = IDLE;
          end else if (cnt >= 4'd5) begin
            address_n   = bbuf[11:7];
            sym_valid_n = 1'b1;
            bbuf_n      = bbuf << 5;
            cnt_n       = cnt - 4'd5;
          end else if (fifo_empty) begin
            underrun_n  = 1'b1;
            address_n   = IDLE_SYM;
            sym_valid_n = 1'b0;
            bbuf_n      = '0;
            cnt_n       = '0;
            state_n     = DRAIN;
          end else begin
            // A byte arrived too late to refill before this strobe: skip a slot.
            address_n   = IDLE_SYM;
            sym_valid_n = 1'b0;
          end
        end

        DRAIN: begin
          address_n   = IDLE_SYM;
          sym_valid_n = 1'b0;
          if (last_popped) begin
            last_popped_n = 1'b0;
            state_n       = IDLE;
          end
        end

        default: begin
          address_n   = IDLE_SYM;
          sym_valid_n = 1'b0;
          state_n     = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_frame_src.sv
// Directed bench for fsk_frame_src: framing, packing, underrun, backpressure,
// mid-frame reset and back-to-back frames.
module tb_fsk_frame_src;
  import fsk_pkg::*;

  localparam int SYM_GAP = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [4:0] address;
  logic       sym_valid;
  logic       busy;
  logic       underrun;
  fsk_state_t state_dbg;

  int checks = 0;
  int errors = 0;
  int accepts;

  logic [4:0] exp_q[$];

  fsk_frame_src_if bi ();

  fsk_frame_src dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .byte_in   (bi),
    .address   (address),
    .sym_valid (sym_valid),
    .busy      (busy),
    .underrun  (underrun),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sym_step();
    repeat (SYM_GAP - 1) tick();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    bi.din       = b;
    bi.din_last  = last;
    bi.din_valid = 1'b1;
    while (!bi.din_ready && n < 64) begin
      tick();
      n++;
    end
    check("push_wait", 32'(n < 64), 32'd1);
    tick();
    bi.din_valid = 1'b0;
    bi.din_last  = 1'b0;
  endtask

  // scoreboard
  task automatic queue_header();
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 1) ? 5'h1F : 5'h00);
    exp_q.push_back(5'h13);
    exp_q.push_back(5'h09);
    exp_q.push_back(5'h0B);
  endtask

  task automatic play_queue(input string tag);
    logic [4:0] e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      sym_step();
      check({tag, "_addr"}, 32'(address), 32'(e));
      check({tag, "_valid"}, 32'(sym_valid), 32'd1);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_addr"}, 32'(address), 32'h00);
    check({tag, "_idle_valid"}, 32'(sym_valid), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bi.din       = 8'h00;
    bi.din_valid = 1'b0;
    bi.din_last  = 1'b0;

    // reset values
    repeat (3) tick();
    check("rst_addr", 32'(address), 32'h00);
    check("rst_valid", 32'(sym_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_ready", 32'(bi.din_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_ready", 32'(bi.din_ready), 32'd1);
    check("rel_state", 32'(state_dbg), 32'(IDLE));

    // single byte 0xA5 with LAST
    push_byte(8'hA5, 1'b1);
    queue_header();
    exp_q.push_back(5'h14);
    exp_q.push_back(5'h14);
    play_queue("a5");
    check("a5_end_busy", 32'(busy), 32'd0);
    sym_step();
    check_idle("a5");

    // 0xFF, 0x00 with LAST
    push_byte(8'hFF, 1'b0);
    push_byte(8'h00, 1'b1);
    queue_header();
    exp_q.push_back(5'h1F);
    exp_q.push_back(5'h1C);
    exp_q.push_back(5'h00);
    exp_q.push_back(5'h00);
    play_queue("ff00");
    sym_step();
    check_idle("ff00");

    // underrun then drain
    push_byte(8'h12, 1'b0);
    queue_header();
    exp_q.push_back(5'h02);
    play_queue("ur");
    sym_step();
    check("ur_pulse", 32'(underrun), 32'd1);
    check("ur_valid", 32'(sym_valid), 32'd0);
    check("ur_addr", 32'(address), 32'h00);
    check("ur_state", 32'(state_dbg), 32'(DRAIN));
    check("ur_busy", 32'(busy), 32'd1);
    tick();
    check("ur_pulse_end", 32'(underrun), 32'd0);
    push_byte(8'h33, 1'b1);
    sym_step();
    check("drain_state", 32'(state_dbg), 32'(IDLE));
    check("drain_valid", 32'(sym_valid), 32'd0);
    sym_step();
    check_idle("drain");

    // backpressure with enable held low
    accepts = 0;
    bi.din_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bi.din = 8'(i + 1);
      if (bi.din_ready) accepts++;
      tick();
    end
    bi.din_valid = 1'b0;
    check("bp_accepts", 32'(accepts), 32'd4);
    check("bp_ready", 32'(bi.din_ready), 32'd0);
    check("bp_state", 32'(state_dbg), 32'(IDLE));

    // asynchronous reset clears the full FIFO
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(bi.din_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_ready_back", 32'(bi.din_ready), 32'd1);

    // reset in the middle of the sync word
    push_byte(8'hA5, 1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 1) ? 5'h1F : 5'h00);
    exp_q.push_back(5'h13);
    exp_q.push_back(5'h09);
    play_queue("mid");
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_addr", 32'(address), 32'h00);
    check("mid_rst_valid", 32'(sym_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_underrun", 32'(underrun), 32'd0);
    check("mid_rst_ready", 32'(bi.din_ready), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    tick();
    push_byte(8'hA5, 1'b1);
    queue_header();
    exp_q.push_back(5'h14);
    exp_q.push_back(5'h14);
    play_queue("post_rst");
    sym_step();
    check_idle("post_rst");

    // two one-byte frames back to back
    push_byte(8'hA5, 1'b1);
    push_byte(8'h3C, 1'b1);
    queue_header();
    exp_q.push_back(5'h14);
    exp_q.push_back(5'h14);
    queue_header();
    exp_q.push_back(5'h07);
    exp_q.push_back(5'h10);
    play_queue("b2b");
    sym_step();
    check_idle("b2b");

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsk_frame_src.md
# fsk_frame_src

Framed symbol source for the FSK transmitter. It accepts payload bytes over a valid/ready handshake and buffers them. On each symbol strobe it emits one 5-bit symbol address for the symbol LUT: a fixed preamble, then a sync word, then the payload packed 5 bits per symbol. It sits directly upstream of the symbol LUT, in place of the free-running PRN generator, and is driven by the same symbol strobe from the sample clock generator.

## Interface
- PREAMBLE_LEN, 8: number of preamble symbols. Must be even and ≥2.
- SYNC_WORD, 15'h4D2B: sync pattern, sent MSB-first as 3 symbols.
- FIFO_DEPTH, 4: byte FIFO depth. Power of two.
- IDLE_SYM, 5'd0: address driven when no frame is active.

- CLOCK  in  1  system clock (16 MHz).
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  symbol strobe, one-cycle pulse per symbol period.
- DIN  in  8  payload byte.
- DIN_VALID  in  1  DIN holds a valid byte.
- DIN_LAST  in  1  qualifies DIN as the final byte of a frame.
- DIN_READY  out  1  FIFO can accept a byte.
- ADDRESS  out  5  symbol address to the LUT.
- SYM_VALID  out  1  ADDRESS carries a frame symbol, not idle.
- BUSY  out  1  a frame is in progress.
- UNDERRUN  out  1  one-cycle pulse when a frame is aborted for lack of data.

## Operation
- Byte handshake: a transfer occurs when DIN_VALID && DIN_READY. DIN_READY = FIFO not full. The FIFO stores {DIN_LAST, DIN}.
- States and transitions (all advance only on ENABLE):
  - IDLE → PREAMBLE: FIFO non-empty at ENABLE.
  - PREAMBLE: emits 5'h00, 5'h1F alternately, starting with 5'h00, for PREAMBLE_LEN symbols, then → SYNC.
  - SYNC: emits SYNC_WORD[14:10], [9:5], [4:0], then → PAYLOAD.
  - PAYLOAD: emits the top 5 bits of a 12-bit bit buffer per ENABLE.
  - DRAIN: discards FIFO bytes until a LAST byte is popped, then → IDLE.
- Refill: on any cycle with ENABLE low, if bit count ≤4, FIFO non-empty and the frame's LAST byte not yet popped, pop one byte into the buffer below the existing bits and add 8 to the count.
- Payload end: LAST byte already popped and count ≤5 at ENABLE:
  - emit the remaining bits MSB-aligned and zero-padded;
  - go to IDLE;
  - if count is 0, go to IDLE without emitting.
- Underrun: in PAYLOAD with count <5, LAST not popped and FIFO empty at ENABLE:
  - pulse UNDERRUN;
  - drive IDLE_SYM with SYM_VALID low;
  - clear the buffer and go to DRAIN (or to IDLE if the FIFO is empty and LAST was already seen).
- In IDLE: ADDRESS = IDLE_SYM, SYM_VALID = 0.
- BUSY = state ≠ IDLE.

## Timing
- ADDRESS, SYM_VALID and UNDERRUN are registered and update on the clock edge at which ENABLE is sampled high. They hold for the whole symbol period.
- First preamble symbol appears on the first ENABLE edge after the FIFO becomes non-empty. Byte-to-FIFO latency is 1 cycle.
- A push and pop in the same cycle are both allowed; occupancy is unchanged.
- Reset values: ADDRESS = IDLE_SYM, SYM_VALID = 0, BUSY = 0, UNDERRUN = 0, DIN_READY = 0 while RESET_N is low and 1 from the first edge after release.
- Reset asserted mid-frame: FIFO, bit buffer and FSM clear immediately. No partial symbol is held.
- ENABLE during the first cycle after reset release is honoured.
- Bit count never exceeds 12. Refill is blocked when count >4.

## Structure
- Package fsk_pkg:
  - SYM_W = 5;
  - state enum {IDLE, PREAMBLE, SYNC, PAYLOAD, DRAIN};
  - preamble symbol constants PRE_A = 5'h00 and PRE_B = 5'h1F.
- Sub-module fsk_byte_fifo: 9-bit wide, FIFO_DEPTH deep, synchronous FIFO with full/empty flags, async active-low reset.
- Top level: FSM, symbol counter (preamble/sync index), 12-bit bit buffer with 4-bit count, output registers.

## Test plan
- Push 0xA5 with LAST, ENABLE every 128 cycles:
  - ADDRESS sequence is 00,1F ×4, then 13,09,0B, then 14,14;
  - then IDLE_SYM with SYM_VALID = 0 and BUSY = 0.
- Push 0xFF then 0x00 with LAST: payload symbols are 1F,1C,00,00, then idle.
- Push 0x12 without LAST, then nothing more:
  - payload symbol 02;
  - next ENABLE gives UNDERRUN pulse, SYM_VALID = 0 and the DRAIN state;
  - a later push of 0x33 with LAST is discarded and the FSM returns to IDLE with no symbols emitted.
- ENABLE held low, push 6 bytes back to back: DIN_READY drops after the 4th accept and only 4 bytes are stored.
- Assert RESET_N low during the SYNC symbol 09:
  - all outputs return to reset values within the same cycle;
  - a new frame after release starts again with preamble 00.
- Two 1-byte frames pushed back to back: the second preamble starts on the ENABLE right after the first frame's last payload symbol, with no idle gap.
